pwm_timer: RTL and testbench

//   Memory-mapped PWM timer that sits directly downstream of the PID/timer link.

---
 rtl/pwm_timer_pkg.sv | 20 ++
 rtl/pwm_prescaler.sv | 35 +++
 rtl/pwm_timer.sv | 203 ++++++++++++++++++++
 tb/tb_pwm_timer.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_timer_pkg.sv
// Shared definitions for the PWM timer: bus register map, CTRL bit positions
// and the up/down counter direction type.
package pwm_timer_pkg;

    typedef enum logic [1:0] {
        ADDR_CTRL = 2'd0,
        ADDR_PSC  = 2'd1,
        ADDR_ARR  = 2'd2,
        ADDR_CNT  = 2'd3
    } addr_t;

    localparam int CTRL_CEN   = 0;
    localparam int CTRL_CMODE = 1;

    typedef enum logic {
        UP   = 1'b0,
        DOWN = 1'b1
    } dir_t;

endpackage

// File: rtl/pwm_prescaler.sv
// Prescaler: counts 0..psc_i while enabled and flags the wrap cycle as a tick.
// A synchronous clear parks it at 0.
module pwm_prescaler #(
    parameter int PSC_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en_i,
    input  logic             clr_i,
    input  logic [PSC_W-1:0] psc_i,
    output logic             tick_o
);

    logic [PSC_W-1:0] cnt_q, cnt_d;

    assign tick_o = en_i & ~clr_i & (cnt_q == psc_i);

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = (cnt_q == psc_i) ? '0 : cnt_q + PSC_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/pwm_timer.sv
// Memory-mapped two-channel PWM timer with shadow-buffered period and compares.
// Define PWM_CENTER_ALIGN_EN to add the up/down (center-aligned) counting mode.
module pwm_timer
    import pwm_timer_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int PSC_W = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic                    chipSelect,
    input  logic                    write,
    input  logic                    read,
    input  logic [1:0]              address,
    input  logic [31:0]             writeData,
    output logic [31:0]             readData,
    input  logic signed [WIDTH-1:0] cmp1_in,
    input  logic signed [WIDTH-1:0] cmp2_in,
    output logic                    pwm1,
    output logic                    pwm2,
    output logic                    update_evt
);

    logic             wr_en, rd_en, tick, wrap, load, cen_rise, cmode_rd;
    logic             cen_q, cen_d;
    logic [PSC_W-1:0] psc_q, psc_d, psc_sh_q;
    logic [WIDTH-1:0] arr_q, arr_d, arr_sh_q;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH:0]   cmp1_sh_q, cmp2_sh_q;
    logic             pwm1_q, pwm2_q, upd_q;
`ifdef PWM_CENTER_ALIGN_EN
    logic             cmode_q, cmode_d;
    dir_t             dir_q, dir_d;
`endif

    // Compare shadows are one bit wider so ARR+1 (constant-high) fits for any ARR.
    function automatic logic [WIDTH:0] sat_cmp(input logic signed [WIDTH-1:0] v,
                                               input logic [WIDTH-1:0] top);
        logic [WIDTH:0] lim;
        logic [WIDTH:0] mag;
        lim = {1'b0, top} + (WIDTH+1)'(1);
        mag = {1'b0, v};
        if (v[WIDTH-1]) begin
            return '0;
        end else if (mag > lim) begin
            return lim;
        end else begin
            return mag;
        end
    endfunction

    assign wr_en = chipSelect & write;
    assign rd_en = chipSelect & read;

    always_comb begin
        cen_d = cen_q;
        psc_d = psc_q;
        arr_d = arr_q;
        if (wr_en) begin
            case (addr_t'(address))
                ADDR_CTRL: cen_d = writeData[CTRL_CEN];
                ADDR_PSC:  psc_d = writeData[PSC_W-1:0];
                ADDR_ARR:  arr_d = writeData[WIDTH-1:0];
                default:   ;
            endcase
        end
    end

`ifdef PWM_CENTER_ALIGN_EN
    assign cmode_d  = (wr_en && addr_t'(address) == ADDR_CTRL) ? writeData[CTRL_CMODE] : cmode_q;
    assign cmode_rd = cmode_q;
`else
    assign cmode_rd = 1'b0;
`endif

    assign cen_rise = cen_d & ~cen_q;

    pwm_prescaler #(.PSC_W(PSC_W)) u_psc (
        .clk   (clk),
        .rst   (rst),
        .en_i  (en & cen_q),
        .clr_i (~cen_q),
        .psc_i (psc_sh_q),
        .tick_o(tick)
    );

    always_comb begin
        cnt_d = cnt_q;
        wrap  = 1'b0;
`ifdef PWM_CENTER_ALIGN_EN
        dir_d = dir_q;
        if (!cen_q || !cmode_q) begin
            dir_d = UP;
        end
`endif
        if (!cen_q) begin
            cnt_d = '0;
        end else if (tick) begin
`ifdef PWM_CENTER_ALIGN_EN
            if (cmode_q) begin
                // Reload happens only at the bottom of the triangle.
                case (dir_q)
                    UP: begin
                        if (cnt_q >= arr_sh_q) begin
                            if (arr_sh_q == '0) begin
                                wrap = 1'b1;
                            end else begin
                                dir_d = DOWN;
                                cnt_d = arr_sh_q - WIDTH'(1);
                            end
                        end else begin
                            cnt_d = cnt_q + WIDTH'(1);
                        end
                    end
                    DOWN: begin
                        if (cnt_q <= WIDTH'(1)) begin
                            cnt_d = '0;
                            dir_d = UP;
                            wrap  = 1'b1;
                        end else begin
                            cnt_d = cnt_q - WIDTH'(1);
                        end
                    end
                    default: dir_d = UP;
                endcase
            end else
`endif
            if (cnt_q >= arr_sh_q) begin
                cnt_d = '0;
                wrap  = 1'b1;
            end else begin
                cnt_d = cnt_q + WIDTH'(1);
            end
        end
    end

    // Shadow reload takes the post-write preload so a same-cycle bus write lands now.
    assign load = wrap | cen_rise;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cen_q     <= 1'b0;
            psc_q     <= '0;
            arr_q     <= '0;
            cnt_q     <= '0;
            psc_sh_q  <= '0;
            arr_sh_q  <= '0;
            cmp1_sh_q <= '0;
            cmp2_sh_q <= '0;
            pwm1_q    <= 1'b0;
            pwm2_q    <= 1'b0;
            upd_q     <= 1'b0;
        end else begin
            cen_q  <= cen_d;
            psc_q  <= psc_d;
            arr_q  <= arr_d;
            cnt_q  <= cnt_d;
            upd_q  <= load;
            pwm1_q <= cen_q & ({1'b0, cnt_q} < cmp1_sh_q);
            pwm2_q <= cen_q & ({1'b0, cnt_q} < cmp2_sh_q);
            if (load) begin
                psc_sh_q  <= psc_d;
                arr_sh_q  <= arr_d;
                cmp1_sh_q <= sat_cmp(cmp1_in, arr_d);
                cmp2_sh_q <= sat_cmp(cmp2_in, arr_d);
            end
        end
    end

`ifdef PWM_CENTER_ALIGN_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cmode_q <= 1'b0;
            dir_q   <= UP;
        end else begin
            cmode_q <= cmode_d;
            dir_q   <= dir_d;
        end
    end
`endif

    always_comb begin
        readData = '0;
        if (rd_en) begin
            case (addr_t'(address))
                ADDR_CTRL: begin
                    readData[CTRL_CEN]   = cen_q;
                    readData[CTRL_CMODE] = cmode_rd;
                end
                ADDR_PSC: readData = 32'(psc_q);
                ADDR_ARR: readData = 32'(arr_q);
                ADDR_CNT: readData = 32'(cnt_q);
                default:  readData = '0;
            endcase
        end
    end

    assign pwm1       = pwm1_q;
    assign pwm2       = pwm2_q;
    assign update_evt = upd_q;

endmodule

// File: tb/tb_pwm_timer.sv
// Self-checking bench for pwm_timer: register table, directed corner sequences and
// randomized runs against an arithmetic model of counter, compare and update timing.
module tb_pwm_timer;

    logic               clk = 1'b0;
    logic               rst;
    logic               en;
    logic               chipSelect;
    logic               write;
    logic               read;
    logic [1:0]         address;
    logic [31:0]        writeData;
    logic [31:0]        readData;
    logic signed [31:0] cmp1_in;
    logic signed [31:0] cmp2_in;
    logic               pwm1;
    logic               pwm2;
    logic               update_evt;

    int n_tests = 0;
    int n_fail  = 0;

    pwm_timer dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .chipSelect(chipSelect),
        .write     (write),
        .read      (read),
        .address   (address),
        .writeData (writeData),
        .readData  (readData),
        .cmp1_in   (cmp1_in),
        .cmp2_in   (cmp2_in),
        .pwm1      (pwm1),
        .pwm2      (pwm2),
        .update_evt(update_evt)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        cs;
        logic        wr;
        logic [1:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp;
    } reg_vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%08h) required %0d (0x%08h)", name, act, act, exp, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        chipSelect = 1'b1;
        write      = 1'b1;
        read       = 1'b0;
        address    = a;
        writeData  = d;
        step();
        chipSelect = 1'b0;
        write      = 1'b0;
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
        chipSelect = 1'b1;
        read       = 1'b1;
        write      = 1'b0;
        address    = a;
        #1;
        d = readData;
        chipSelect = 1'b0;
        read       = 1'b0;
    endtask

    function automatic int sat_ref(input int c, input int a);
        if (c < 0) return 0;
        if (c > a + 1) return a + 1;
        return c;
    endfunction

    // Edge mode: one tick every p+1 clocks, counter value is ticks modulo a+1.
    function automatic int cnt_ref(input int k, input int p, input int a);
        return (k / (p + 1)) % (a + 1);
    endfunction

    function automatic int tri_ref(input int k, input int a);
        int ph;
        ph = k % (2 * a);
        return (ph <= a) ? ph : 2 * a - ph;
    endfunction

    task automatic start_run(input int p, input int a, input int c1, input int c2);
        bus_write(2'd1, 32'(p));
        bus_write(2'd2, 32'(a));
        cmp1_in = c1;
        cmp2_in = c2;
        bus_write(2'd0, 32'd1);
        chipSelect = 1'b1;
        read       = 1'b1;
        address    = 2'd3;
        #1;
    endtask

    task automatic stop_run();
        chipSelect = 1'b0;
        read       = 1'b0;
        bus_write(2'd0, 32'd0);
        step();
    endtask

    task automatic run_check(input string tag, input int p, input int a, input int c1,
                             input int c2, input int n);
        int s1, s2;
        s1 = sat_ref(c1, a);
        s2 = sat_ref(c2, a);
        start_run(p, a, c1, c2);
        for (int k = 0; k < n; k++) begin
            chk({tag, ".cnt"}, readData, 32'(cnt_ref(k, p, a)));
            chk({tag, ".pwm1"}, 32'(pwm1), (k == 0) ? 32'd0 : 32'(cnt_ref(k - 1, p, a) < s1));
            chk({tag, ".pwm2"}, 32'(pwm2), (k == 0) ? 32'd0 : 32'(cnt_ref(k - 1, p, a) < s2));
            chk({tag, ".upd"}, 32'(update_evt), 32'((k % ((a + 1) * (p + 1))) == 0));
            step();
        end
        stop_run();
    endtask

    reg_vec_t    vecs[$];
    logic [31:0] rd;

    initial begin
        int upds[$];
        int hi1, hi2;

        rst        = 1'b0;
        en         = 1'b1;
        chipSelect = 1'b0;
        write      = 1'b0;
        read       = 1'b0;
        address    = 2'd0;
        writeData  = '0;
        cmp1_in    = '0;
        cmp2_in    = '0;
        step();
        step();
        chk("reset.pwm1", 32'(pwm1), 32'd0);
        chk("reset.pwm2", 32'(pwm2), 32'd0);
        chk("reset.upd", 32'(update_evt), 32'd0);
        chk("reset.rdata_idle", readData, 32'd0);
        rst = 1'b1;
        step();

        // Register access table: optional write, then read back the same word.
        vecs.push_back('{1'b1, 1'b0, 2'd0, 32'h0, 32'h0});
        vecs.push_back('{1'b1, 1'b0, 2'd1, 32'h0, 32'h0});
        vecs.push_back('{1'b1, 1'b0, 2'd2, 32'h0, 32'h0});
        vecs.push_back('{1'b1, 1'b0, 2'd3, 32'h0, 32'h0});
        vecs.push_back('{1'b1, 1'b1, 2'd1, 32'h1234ABCD, 32'h0000ABCD});
        vecs.push_back('{1'b1, 1'b1, 2'd2, 32'hDEADBEEF, 32'hDEADBEEF});
        vecs.push_back('{1'b1, 1'b1, 2'd3, 32'h00000055, 32'h0});
        vecs.push_back('{1'b0, 1'b0, 2'd2, 32'h0, 32'h0});
        vecs.push_back('{1'b1, 1'b1, 2'd0, 32'hFFFFFFFC, 32'h0});
        vecs.push_back('{1'b1, 1'b1, 2'd2, 32'h0, 32'h0});
        vecs.push_back('{1'b1, 1'b1, 2'd1, 32'h0, 32'h0});
        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].wr) bus_write(vecs[i].addr, vecs[i].wdata);
            chipSelect = vecs[i].cs;
            read       = 1'b1;
            address    = vecs[i].addr;
            #1;
            chk($sformatf("regtab[%0d]", i), readData, vecs[i].exp);
            chipSelect = 1'b0;
            read       = 1'b0;
            step();
        end

        bus_write(2'd0, 32'd2);
        bus_read(2'd0, rd);
`ifdef PWM_CENTER_ALIGN_EN
        chk("ctrl.cmode_rw", rd, 32'd2);
`else
        chk("ctrl.cmode_raz", rd, 32'd0);
`endif
        bus_write(2'd0, 32'd0);
        step();

        // Basic 50% duty, saturation both ways, prescaled period.
        run_check("t1", 0, 9, 5, 0, 25);
        run_check("t2", 0, 9, -2048, 2048, 25);
        run_check("t4", 3, 4, 2, 5, 45);
        run_check("arr0", 0, 0, 1, -1, 6);

        // Mid-period ARR/compare change only takes effect at the next update.
        start_run(0, 9, 5, 0);
        chipSelect = 1'b0;
        read       = 1'b0;
        hi1 = 0;
        hi2 = 0;
        for (int k = 0; k < 45; k++) begin
            if (k == 4) begin
                chipSelect = 1'b1;
                write      = 1'b1;
                address    = 2'd2;
                writeData  = 32'd19;
                cmp1_in    = 10;
            end
            if (k == 5) begin
                chipSelect = 1'b0;
                write      = 1'b0;
            end
            if (update_evt) upds.push_back(k);
            if (k >= 1 && k <= 10 && pwm1) hi1++;
            if (k >= 11 && k <= 30 && pwm1) hi2++;
            step();
        end
        chk("t3.num_upd", 32'(upds.size()), 32'd3);
        if (upds.size() >= 3) begin
            chk("t3.upd1", 32'(upds[1]), 32'd10);
            chk("t3.upd2", 32'(upds[2]), 32'd30);
        end
        chk("t3.high_p1", 32'(hi1), 32'd5);
        chk("t3.high_p2", 32'(hi2), 32'd10);
        stop_run();

        // Global enable low freezes the counter.
        start_run(0, 9, 5, 0);
        step(); step(); step();
        en = 1'b0;
        for (int k = 0; k < 5; k++) step();
        chk("en.frozen_cnt", readData, 32'd3);
        chk("en.no_upd", 32'(update_evt), 32'd0);
        en = 1'b1;
        step();
        chk("en.resume_cnt", readData, 32'd4);
        stop_run();

        // Asynchronous reset while running.
        start_run(0, 9, 5, 10);
        for (int k = 0; k < 6; k++) step();
        chk("t5.cnt_before", readData, 32'd6);
        chk("t5.pwm2_before", 32'(pwm2), 32'd1);
        #2;
        rst = 1'b0;
        #1;
        chk("t5.cnt_async", readData, 32'd0);
        chk("t5.pwm1_async", 32'(pwm1), 32'd0);
        chk("t5.pwm2_async", 32'(pwm2), 32'd0);
        chk("t5.upd_async", 32'(update_evt), 32'd0);
        address = 2'd0;
        #1;
        chk("t5.ctrl_async", readData, 32'd0);
        step();
        rst = 1'b1;
        for (int k = 0; k < 15; k++) step();
        chk("t5.pwm2_after", 32'(pwm2), 32'd0);
        address = 2'd3;
        #1;
        chk("t5.cnt_after", readData, 32'd0);
        chipSelect = 1'b0;
        read       = 1'b0;
        step();

`ifdef PWM_CENTER_ALIGN_EN
        bus_write(2'd1, 32'd0);
        bus_write(2'd2, 32'd4);
        cmp1_in = 2;
        cmp2_in = 0;
        bus_write(2'd0, 32'd3);
        chipSelect = 1'b1;
        read       = 1'b1;
        address    = 2'd3;
        #1;
        for (int k = 0; k < 20; k++) begin
            chk("t6.cnt", readData, 32'(tri_ref(k, 4)));
            chk("t6.pwm1", 32'(pwm1), (k == 0) ? 32'd0 : 32'(tri_ref(k - 1, 4) < 2));
            chk("t6.upd", 32'(update_evt), 32'((k % 8) == 0));
            step();
        end
        stop_run();
`endif

        // Randomized configurations against the arithmetic model.
        for (int t = 0; t < 20; t++) begin
            int p, a, c1, c2;
            p  = int'($urandom_range(0, 3));
            a  = int'($urandom_range(0, 12));
            c1 = int'($urandom_range(0, 40)) - 10;
            c2 = int'($urandom_range(0, 40)) - 10;
            run_check($sformatf("rnd%0d", t), p, a, c1, c2, 2 * (a + 1) * (p + 1) + 3);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
